// File: rtl/mul_execute_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) for the execute stage.
// Holds the Decode/Execute register via stall_mul, then emits a one-cycle writeback strobe.
module mul_execute_unit #(
  parameter logic [4:0] TYPE_MUL    = 5'd10,
  parameter logic [4:0] TYPE_MULH   = 5'd11,
  parameter logic [4:0] TYPE_MULHSU = 5'd12,
  parameter logic [4:0] TYPE_MULHU  = 5'd13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mul_execute,
  input  logic [4:0]  execute_type_execute,
  input  logic [31:0] operand1_execute,
  input  logic [31:0] operand2_execute,
  input  logic [4:0]  rd_execute,
  input  logic        reg_write_execute,
  input  logic        flush,
  output logic        stall_mul,
  output logic        mul_busy,
  output logic        mul_valid,
  output logic [31:0] mul_result,
  output logic [4:0]  mul_rd,
  output logic        mul_reg_write
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] mcand_r;
  logic        neg_r;
  logic        hi_sel_r;
  logic [4:0]  rd_r;
  logic        rw_r;

  logic        op1_signed_s;
  logic        op2_signed_s;
  logic        hi_sel_s;
  logic [32:0] sum_s;
  logic [63:0] acc_next_s;
  logic [63:0] prod_s;
  logic [31:0] result_s;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    if (is_signed && v[31]) begin
      magnitude = ~v + 32'd1;
    end else begin
      magnitude = v;
    end
  endfunction

  // Operand signedness and product-half selection; unknown codes behave as MUL.
  always_comb begin
    op1_signed_s = 1'b0;
    op2_signed_s = 1'b0;
    hi_sel_s     = 1'b0;
    case (execute_type_execute)
      TYPE_MUL: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        hi_sel_s     = 1'b0;
      end
      TYPE_MULH: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b1;
        hi_sel_s     = 1'b1;
      end
      TYPE_MULHSU: begin
        op1_signed_s = 1'b1;
        op2_signed_s = 1'b0;
        hi_sel_s     = 1'b1;
      end
      TYPE_MULHU: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        hi_sel_s     = 1'b1;
      end
      default: begin
        op1_signed_s = 1'b0;
        op2_signed_s = 1'b0;
        hi_sel_s     = 1'b0;
      end
    endcase
  end

  // One shift-add iteration; the 33-bit sum keeps the carry that shifts into bit 63.
  always_comb begin
    sum_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, mcand_r} : 33'd0);
    acc_next_s = {sum_s, acc_r[31:1]};
    prod_s     = neg_r ? (~acc_next_s + 64'd1) : acc_next_s;
    result_s   = hi_sel_r ? prod_s[63:32] : prod_s[31:0];
  end

  assign stall_mul = rst_n & ~flush &
                     (((state_r == IDLE) & mul_execute) | (state_r == BUSY));

  // Control FSM, datapath registers and the registered writeback packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= 5'd0;
      acc_r         <= 64'd0;
      mcand_r       <= 32'd0;
      neg_r         <= 1'b0;
      hi_sel_r      <= 1'b0;
      rd_r          <= 5'd0;
      rw_r          <= 1'b0;
      mul_busy      <= 1'b0;
      mul_valid     <= 1'b0;
      mul_result    <= 32'd0;
      mul_rd        <= 5'd0;
      mul_reg_write <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mul_valid <= 1'b0;
          if (mul_execute && !flush) begin
            mcand_r  <= magnitude(operand1_execute, op1_signed_s);
            acc_r    <= {32'd0, magnitude(operand2_execute, op2_signed_s)};
            neg_r    <= (op1_signed_s & operand1_execute[31]) ^
                        (op2_signed_s & operand2_execute[31]);
            hi_sel_r <= hi_sel_s;
            rd_r     <= rd_execute;
            rw_r     <= reg_write_execute;
            cnt_r    <= 5'd0;
            mul_busy <= 1'b1;
            state_r  <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (flush) begin
            mul_busy <= 1'b0;
            state_r  <= IDLE;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + 5'd1;
            if (cnt_r == 5'd31) begin
              mul_busy      <= 1'b0;
              mul_valid     <= 1'b1;
              mul_result    <= result_s;
              mul_rd        <= rd_r;
              mul_reg_write <= rw_r;
              state_r       <= DONE;
            end else begin
              state_r <= BUSY;
            end
          end
        end
        DONE: begin
          mul_valid <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          mul_busy  <= 1'b0;
          mul_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_execute_unit.sv
// Randomised self-checking bench for mul_execute_unit against a cycle-count/arithmetic model.
module tb_mul_execute_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mul_execute;
  logic [4:0]  execute_type_execute;
  logic [31:0] operand1_execute;
  logic [31:0] operand2_execute;
  logic [4:0]  rd_execute;
  logic        reg_write_execute;
  logic        flush;
  logic        stall_mul;
  logic        mul_busy;
  logic        mul_valid;
  logic [31:0] mul_result;
  logic [4:0]  mul_rd;
  logic        mul_reg_write;

  mul_execute_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .mul_execute          (mul_execute),
    .execute_type_execute (execute_type_execute),
    .operand1_execute     (operand1_execute),
    .operand2_execute     (operand2_execute),
    .rd_execute           (rd_execute),
    .reg_write_execute    (reg_write_execute),
    .flush                (flush),
    .stall_mul            (stall_mul),
    .mul_busy             (mul_busy),
    .mul_valid            (mul_valid),
    .mul_result           (mul_result),
    .mul_rd               (mul_rd),
    .mul_reg_write        (mul_reg_write)
  );

  always #5 clk = ~clk;

  // age: 0 = nothing accepted, 1..32 = cycles since acceptance while computing, 33 = strobe cycle
  int          age;
  logic [31:0] pend_res, last_res;
  logic [4:0]  pend_rd, last_rd;
  logic        pend_rw, last_rw;
  bit          held;
  int          cyc;
  int          checks;
  int          errors;

  function automatic logic [31:0] ref_mul(input logic [4:0] t, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, p;
    sa = (t == 5'd11 || t == 5'd12) ? longint'($signed(a)) : longint'({32'd0, a});
    sb = (t == 5'd11) ? longint'($signed(b)) : longint'({32'd0, b});
    p  = sa * sb;
    if (t >= 5'd11 && t <= 5'd13) return p[63:32];
    return p[31:0];
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_stall"},  stall_mul, 0);
    chk({tag, "_busy"},   mul_busy, 0);
    chk({tag, "_valid"},  mul_valid, 0);
    chk({tag, "_result"}, mul_result, 0);
    chk({tag, "_rd"},     mul_rd, 0);
    chk({tag, "_rw"},     mul_reg_write, 0);
  endtask

  // One clock cycle: called just after a negedge with this cycle's inputs driven.
  task automatic tick();
    bit st_exp;
    #1;
    st_exp = !flush && ((age == 0 && mul_execute) || (age >= 1 && age <= 32));
    chk("stall_mul", stall_mul, st_exp);
    if (age == 0) begin
      if (mul_execute && !flush) begin
        age      = 1;
        pend_res = ref_mul(execute_type_execute, operand1_execute, operand2_execute);
        pend_rd  = rd_execute;
        pend_rw  = reg_write_execute;
      end
    end else if (age <= 32) begin
      if (flush) begin
        age = 0;
      end else begin
        age++;
        if (age == 33) begin
          last_res = pend_res;
          last_rd  = pend_rd;
          last_rw  = pend_rw;
        end
      end
    end else begin
      age = 0;
    end
    held = st_exp;
    @(negedge clk);
    cyc++;
    chk("mul_busy",      mul_busy, (age >= 1 && age <= 32));
    chk("mul_valid",     mul_valid, (age == 33));
    chk("mul_result",    mul_result, last_res);
    chk("mul_rd",        mul_rd, last_rd);
    chk("mul_reg_write", mul_reg_write, last_rw);
  endtask

  task automatic run_op(input logic [4:0] t, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic [31:0] lit,
                        output int nstall, output int vcyc);
    bit got;
    mul_execute          = 1'b1;
    execute_type_execute = t;
    operand1_execute     = a;
    operand2_execute     = b;
    rd_execute           = rd;
    reg_write_execute    = rw;
    flush                = 1'b0;
    chk("model_pin", ref_mul(t, a, b), lit);
    nstall = 0;
    vcyc   = 0;
    got    = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (held) nstall++;
      if (age == 33) begin
        got  = 1'b1;
        vcyc = cyc;
        chk("lit_result", mul_result, lit);
        chk("lit_rd", mul_rd, rd);
      end
    end
    if (!got) chk("op_timeout", 0, 1);
    tick();
    mul_execute = 1'b0;
  endtask

  initial begin
    int ns, v1, v2, nv;
    age = 0; held = 1'b0; cyc = 0; checks = 0; errors = 0;
    pend_res = 32'd0; pend_rd = 5'd0; pend_rw = 1'b0;
    last_res = 32'd0; last_rd = 5'd0; last_rw = 1'b0;
    rst_n = 1'b0; mul_execute = 1'b1; execute_type_execute = 5'd10;
    operand1_execute = 32'd3; operand2_execute = 32'd3; rd_execute = 5'd1;
    reg_write_execute = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    mul_execute = 1'b0;
    tick();

    run_op(5'd10, 32'd7, 32'd6, 5'd5, 1'b1, 32'h0000_002A, ns, v1);
    chk("stall_len", ns, 33);
    run_op(5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b1, 32'h0000_0001, ns, v1);
    run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 1'b1, 32'h0000_0000, ns, v1);
    run_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0, 32'hFFFF_FFFE, ns, v1);
    run_op(5'd12, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 1'b1, 32'hFFFF_FFFF, ns, v1);
    run_op(5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, 32'h0000_0000, ns, v1);
    run_op(5'd10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h8000_0000, ns, v1);
    run_op(5'd3,  32'd3,         32'd5,         5'd7, 1'b1, 32'h0000_000F, ns, v1);

    run_op(5'd10, 32'd3, 32'd4, 5'd8, 1'b1, 32'd12, ns, v1);
    run_op(5'd10, 32'd5, 32'd5, 5'd9, 1'b1, 32'd25, ns, v2);
    chk("b2b_spacing", v2 - v1, 34);

    // Flush in the tenth computing cycle
    mul_execute = 1'b1; execute_type_execute = 5'd10;
    operand1_execute = 32'd9; operand2_execute = 32'd9; rd_execute = 5'd10;
    for (int i = 0; i < 20 && age != 10; i++) tick();
    chk("flush_reach", age, 10);
    flush = 1'b1;
    tick();
    chk("flush_idle", mul_busy, 0);
    flush = 1'b0; mul_execute = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mul_valid) nv++;
    end
    chk("flush_no_valid", nv, 0);

    // Asynchronous reset in the twentieth computing cycle
    mul_execute = 1'b1; execute_type_execute = 5'd11;
    operand1_execute = 32'h1234; operand2_execute = 32'h5678; rd_execute = 5'd11;
    for (int i = 0; i < 30 && age != 20; i++) tick();
    chk("reset_reach", age, 20);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_reset");
    age = 0; held = 1'b0;
    last_res = 32'd0; last_rd = 5'd0; last_rw = 1'b0;
    @(negedge clk);
    cyc++;
    chk_zero_outputs("reset_hold");
    rst_n = 1'b1;
    mul_execute = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mul_valid) nv++;
    end
    chk("reset_no_valid", nv, 0);
    run_op(5'd10, 32'h1234, 32'h5678, 5'd12, 1'b1, 32'h0626_0060, ns, v1);

    // Randomised traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        mul_execute = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) < 4) execute_type_execute = 5'(10 + $urandom_range(0, 3));
        else execute_type_execute = 5'($urandom);
        operand1_execute  = rand_op();
        operand2_execute  = rand_op();
        rd_execute        = 5'($urandom);
        reg_write_execute = 1'($urandom);
      end
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; mul_execute = 1'b0;
    repeat (40) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
